// File: rtl/rr_packet_arbiter.sv
// rr_packet_arbiter
//   Round-robin arbiter that shares one valid/ready stream between NUM_IN
//   requesters. The grant is held for a whole packet, from its first beat until
//   a beat with last=1 is accepted. Priority then rotates to the input after
//   the winner. Accepted beats go into a registered 2-entry skid buffer, so
//   t_ready never depends combinationally on i0_ready.
//
//   Handshake: a beat moves on a channel in any cycle where valid and ready are
//   both high at the rising clock edge. valid must not wait for ready. For the
//   output stream, i0_data/i0_last stay stable while i0_valid is high and
//   i0_ready is low.
//
// Ports
//   clk, rstf       clock; asynchronous active-low reset
//   t_data          NUM_IN packed beats, slice k = [k*DWIDTH +: DWIDTH]
//   t_valid/t_last  per-requester beat valid / end-of-packet
//   t_ready         per-requester accept (only the locked requester, never in IDLE)
//   i0_data/i0_last head beat of the skid buffer
//   i0_valid        skid buffer not empty
//   i0_ready        downstream accept
//   grant_id        current or most recent winner
//   busy            a packet is locked (exposes the FSM state)
module rr_packet_arbiter #(
    parameter int NUM_IN = 4,
    parameter int DWIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rstf,
    input  logic [NUM_IN*DWIDTH-1:0]  t_data,
    input  logic [NUM_IN-1:0]         t_valid,
    input  logic [NUM_IN-1:0]         t_last,
    output logic [NUM_IN-1:0]         t_ready,
    output logic [DWIDTH-1:0]         i0_data,
    output logic                      i0_last,
    output logic                      i0_valid,
    input  logic                      i0_ready,
    output logic [$clog2(NUM_IN)-1:0] grant_id,
    output logic                      busy
);
    localparam int IW = $clog2(NUM_IN);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_IN - 1);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d, grant_d;
    logic [IW-1:0]      winner;
    logic               found;

    logic [DWIDTH-1:0]  sel_data;
    logic               sel_last, sel_valid;

    logic [DWIDTH-1:0]  buf_data [2];
    logic [1:0]         buf_last;
    logic               wr_idx, rd_idx;
    logic [1:0]         count;
    logic               space, push, pop;

    // Scan ptr, ptr+1, ..., wrapping, and take the first requester with valid set.
    always_comb begin : scan
        int idx;
        winner = ptr_q;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NUM_IN; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_IN) idx = idx - NUM_IN;
            if (!found && t_valid[IW'(idx)]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

    // Each slice is gated by an explicit compare, so unselected slices
    // (possibly X) never reach the buffer.
    always_comb begin
        sel_data  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (grant_id == IW'(k)) begin
                sel_data  = t_data[k*DWIDTH +: DWIDTH];
                sel_last  = t_last[k];
                sel_valid = t_valid[k];
            end
        end
    end

    // Ready comes only from registered state, so no path back from i0_ready.
    assign space = (count != 2'd2);

    always_comb begin
        t_ready = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            t_ready[k] = (state_q == LOCKED) && (grant_id == IW'(k)) && space;
        end
    end

    assign push     = (state_q == LOCKED) && sel_valid && space;
    assign pop      = i0_valid && i0_ready;
    assign busy     = (state_q == LOCKED);
    assign i0_valid = (count != 2'd0);
    assign i0_data  = buf_data[rd_idx];
    assign i0_last  = buf_last[rd_idx];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_id;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = winner;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                // Release only when the last beat is actually accepted.
                if (push && sel_last) begin
                    state_d = IDLE;
                    ptr_d   = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            grant_id <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_id <= grant_d;
        end
    end

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_last    <= '0;
            wr_idx      <= 1'b0;
            rd_idx      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (push) begin
                buf_data[wr_idx] <= sel_data;
                buf_last[wr_idx] <= sel_last;
                wr_idx           <= ~wr_idx;
            end
            if (pop) rd_idx <= ~rd_idx;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Directed bench for rr_packet_arbiter (NUM_IN=4, DWIDTH=32).
// Inputs are driven on the falling edge. Handshakes are sampled just before
// the rising edge, and outputs are checked on the falling edge.
// Beat data encodes requester, packet tag and beat index as
// (k<<24)|(tag<<8)|beat. Tests queue packets in their hand-derived output order.
module tb_rr_packet_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk;
    logic            rstf;
    logic [N*DW-1:0] t_data;
    logic [N-1:0]    t_valid;
    logic [N-1:0]    t_last;
    logic [N-1:0]    t_ready;
    logic [DW-1:0]   i0_data;
    logic            i0_last;
    logic            i0_valid;
    logic            i0_ready;
    logic [1:0]      grant_id;
    logic            busy;

    rr_packet_arbiter #(.NUM_IN(N), .DWIDTH(DW)) dut (
        .clk      (clk),
        .rstf     (rstf),
        .t_data   (t_data),
        .t_valid  (t_valid),
        .t_last   (t_last),
        .t_ready  (t_ready),
        .i0_data  (i0_data),
        .i0_last  (i0_last),
        .i0_valid (i0_valid),
        .i0_ready (i0_ready),
        .grant_id (grant_id),
        .busy     (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // source model and scoreboard
    logic [DW-1:0] src_data [N][16];
    logic          src_last [N][16];
    int            src_n   [N];
    int            src_pos [N];
    logic [N-1:0]  hold;
    logic          rdy;
    logic [DW:0]   exp_q[$];
    int            cyc;
    logic          chk_gap;
    logic          have_prev;
    int            prev_cyc;
    logic          prev_last;

    task automatic clear_src();
        for (int k = 0; k < N; k++) begin
            src_n[k]   = 0;
            src_pos[k] = 0;
        end
        hold      = '0;
        have_prev = 1'b0;
    endtask

    task automatic add_pkt(input int k, input int len, input int tag);
        logic [DW-1:0] d;
        for (int b = 0; b < len; b++) begin
            d = DW'(k << 24) | DW'(tag << 8) | DW'(b);
            src_data[k][src_n[k]] = d;
            src_last[k][src_n[k]] = (b == len - 1);
            src_n[k]++;
            exp_q.push_back({(b == len - 1), d});
        end
    endtask

    function automatic logic all_sent();
        logic r;
        r = 1'b1;
        for (int k = 0; k < N; k++) if (src_pos[k] < src_n[k]) r = 1'b0;
        return r;
    endfunction

    // One clock cycle: drive, sample handshakes, advance to the next falling edge.
    task automatic step();
        logic [N-1:0] in_acc;
        logic [DW:0]  e;
        for (int k = 0; k < N; k++) begin
            if (src_pos[k] < src_n[k] && !hold[k]) begin
                t_valid[k]            = 1'b1;
                t_data[k*DW +: DW]    = src_data[k][src_pos[k]];
                t_last[k]             = src_last[k][src_pos[k]];
            end else begin
                t_valid[k]            = 1'b0;
                t_data[k*DW +: DW]    = 'x;
                t_last[k]             = 1'b0;
            end
        end
        i0_ready = rdy;
        #1;
        in_acc = t_valid & t_ready;
        if (i0_valid && i0_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", {i0_last, i0_data}, 64'hdead);
            end else begin
                e = exp_q.pop_front();
                check("out_beat", {i0_last, i0_data}, e);
            end
            if (chk_gap && have_prev) check("out_gap", cyc - prev_cyc, prev_last ? 2 : 1);
            have_prev = 1'b1;
            prev_cyc  = cyc;
            prev_last = i0_last;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int k = 0; k < N; k++) if (in_acc[k]) src_pos[k]++;
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int n;
        n = 0;
        while ((!all_sent() || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check(tag, {all_sent(), 31'(exp_q.size())}, {1'b1, 31'd0});
    endtask

    initial begin
        rstf     = 1'b0;
        t_data   = '0;
        t_valid  = '1;
        t_last   = '0;
        i0_ready = 1'b0;
        rdy      = 1'b0;
        cyc      = 0;
        chk_gap  = 1'b0;
        clear_src();

        // Reset with every requester valid.
        repeat (3) @(negedge clk);
        check("rst_t_ready", t_ready, 4'b0000);
        check("rst_i0_valid", i0_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_grant", grant_id, 2'd0);
        check("rst_i0_data", {i0_last, i0_data}, 33'd0);
        rstf = 1'b1;
        @(negedge clk);
        check("first_grant", grant_id, 2'd0);
        check("first_t_ready", t_ready, 4'b0001);
        check("first_busy", busy, 1'b1);
        rstf = 1'b0;
        t_valid = '0;
        #1;
        check("rst_async_busy", busy, 1'b0);
        @(negedge clk);
        rstf = 1'b1;
        @(negedge clk);

        // Four requesters with 3-beat packets; requester 0 has a second packet.
        // Expected order 0,1,2,3,0.
        clear_src();
        rdy = 1'b1;
        chk_gap = 1'b1;
        add_pkt(0, 3, 0);
        add_pkt(1, 3, 0);
        add_pkt(2, 3, 0);
        add_pkt(3, 3, 0);
        add_pkt(0, 3, 1);
        run_until_done("rr_drain", 100);
        check("rr_last_grant", grant_id, 2'd0);

        // Requester 2 alone with back-to-back 1-beat packets; ptr is now 1.
        clear_src();
        for (int p = 0; p < 4; p++) add_pkt(2, 1, 2 + p);
        for (int n = 0; n < 40 && (!all_sent() || exp_q.size() != 0); n++) begin
            step();
            check("solo_others_idle", t_ready & 4'b1011, 4'b0000);
        end
        check("solo_drain", exp_q.size(), 0);
        chk_gap = 1'b0;

        // Requester 1 granted (ptr=3) while downstream stalls.
        clear_src();
        rdy = 1'b0;
        add_pkt(1, 4, 7);
        step();
        check("stall_grant", grant_id, 2'd1);
        step();
        step();
        check("stall_valid", i0_valid, 1'b1);
        check("stall_head_a", {i0_last, i0_data}, {1'b0, 32'h0100_0700});
        step();
        step();
        check("stall_full_ready", t_ready, 4'b0000);
        check("stall_accepted", src_pos[1], 2);
        check("stall_head_b", {i0_last, i0_data}, {1'b0, 32'h0100_0700});
        rdy = 1'b1;
        run_until_done("stall_drain", 50);

        // Requester 3 granted (ptr=2), drops valid mid-packet while 0 waits.
        clear_src();
        add_pkt(3, 4, 9);
        add_pkt(0, 1, 9);
        step();
        check("gap_grant", grant_id, 2'd3);
        step();
        step();
        hold[3] = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step();
            check("gap_t_ready0", t_ready[0], 1'b0);
            check("gap_busy", busy, 1'b1);
        end
        hold[3] = 1'b0;
        run_until_done("gap_drain", 50);
        check("wrap_grant", grant_id, 2'd0);

        // Reset mid-packet with two beats buffered (ptr=1, winner 2).
        clear_src();
        rdy = 1'b0;
        add_pkt(2, 4, 11);
        step();
        check("mid_grant", grant_id, 2'd2);
        step();
        step();
        check("mid_full_valid", i0_valid, 1'b1);
        check("mid_full_ready", t_ready, 4'b0000);
        rstf = 1'b0;
        #1;
        check("mid_rst_valid", i0_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", t_ready, 4'b0000);
        exp_q.delete();
        clear_src();
        @(negedge clk);
        rstf = 1'b1;
        rdy = 1'b1;
        add_pkt(1, 1, 12);
        add_pkt(3, 1, 12);
        step();
        check("post_rst_grant", grant_id, 2'd1);
        check("post_rst_ready", t_ready, 4'b0010);
        run_until_done("post_rst_drain", 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_packet_arbiter.md
Name: rr_packet_arbiter

Overview:
- N-input round-robin arbiter that shares one valid/ready stream output between NUM_IN requesters.
- Arbitrates per packet: the grant locks on a requester from its first beat until a beat with last=1 is accepted.
- Priority then rotates to the input after the winner.
- Sits in front of any shared single-port stream consumer.
- Output passes through a registered 2-entry skid buffer, so there is no combinational path from i0_ready to t_ready.

Parameters:
- NUM_IN, 4, number of requesters; legal range 2..16.
- DWIDTH, 32, data width per beat.

Ports:
- clk  input  1  clock.
- rstf  input  1  reset, asynchronous, active-low.
- t_data  input  NUM_IN*DWIDTH  requester data; slice k is bits [k*DWIDTH +: DWIDTH].
- t_valid  input  NUM_IN  per-requester beat valid.
- t_last  input  NUM_IN  per-requester end-of-packet marker.
- t_ready  output  NUM_IN  per-requester accept.
- i0_data  output  DWIDTH  granted beat data.
- i0_last  output  1  granted beat last marker.
- i0_valid  output  1  output beat valid.
- i0_ready  input  1  downstream accept.
- grant_id  output  $clog2(NUM_IN)  index of the current or most recent winner.
- busy  output  1  high while a packet is locked.

Behaviour:
- Reset (async assert, sync release): state=IDLE, ptr=0, grant_id=0, skid buffer empty (count=0), i0_valid=0, i0_data=0, i0_last=0, t_ready=all 0, busy=0.
- Transfer rules:
  - Input beat is accepted when t_valid[k]&t_ready[k].
  - Output beat is accepted when i0_valid&i0_ready.
- State IDLE:
  - t_ready all 0.
  - If any t_valid is set, the winner is the first set bit scanning ptr, ptr+1, …, NUM_IN-1, 0, …, ptr-1.
  - Register the winner into grant_id and go to LOCKED.
  - No t_valid: stay in IDLE, grant_id holds.
- State LOCKED:
  - busy=1.
  - t_ready[grant_id] = (count<2), registered-derived; every other t_ready bit is 0.
  - Each accepted beat (data + last) is pushed into the skid buffer.
  - Accepted beat with t_last=1: next state IDLE, ptr <= (grant_id==NUM_IN-1) ? 0 : grant_id+1.
  - t_valid[grant_id] dropping mid-packet: stay LOCKED, no timeout.
  - Other requesters are never served mid-packet.
- Arbitration latency:
  - One IDLE cycle per packet. Request seen in cycle n → t_ready high in cycle n+1 (if the buffer is not full).
  - A single-beat packet therefore occupies 2 cycles of input bandwidth.
- Skid buffer:
  - 2-entry FIFO; i0_valid = (count!=0); i0_data/i0_last come from the head entry.
  - Push and pop in the same cycle leaves count unchanged.
  - Input accept in cycle n → i0_valid in cycle n+1.
  - With i0_ready held high, each packet body sustains 1 beat/cycle.
  - While i0_valid&!i0_ready, i0_data and i0_last hold stable.
  - Beat order within a packet is preserved; packets never interleave at the output.
- Boundary conditions:
  - count==2: no push, even if a pop happens the same cycle.
  - Last beat accepted while other requesters are valid: one IDLE bubble, then rotated grant.
  - Only the just-served requester is valid: it wins again after the bubble.
  - ptr wraps from NUM_IN-1 to 0.
  - Reset mid-packet: buffered beats are discarded, lock released, ptr=0.
  - X on unselected t_data slices must not propagate to i0_data.

Test Plan:
- Reset with all t_valid=1: t_ready=0, i0_valid=0, busy=0. After release, first grant_id=0 and t_ready=4'b0001 one cycle later.
- NUM_IN=4, all four requesters send 3-beat packets, i0_ready=1: output packet order is 0,1,2,3,0; beats within each packet stay contiguous; i0_last is set on every 3rd beat; 1 bubble cycle between packets.
- Requester 2 only, 1-beat packets back to back: t_ready[2] high on alternate cycles; output data matches input order.
- Grant on requester 1 with i0_ready=0 for 5 cycles: two beats are buffered, then t_ready[1]=0 and i0_data is stable. Release i0_ready: beats drain in order with no loss or duplicates.
- Grant held by requester 3 while t_valid[3] drops for 4 cycles mid-packet and t_valid[0] is high: t_ready[0] stays 0 and busy=1. Requester 3 resumes and finishes; next winner is 0 (wrap).
- Assert rstf low mid-packet with 2 beats buffered: i0_valid=0 immediately; after release the grant goes to the lowest valid index starting at ptr=0.
